// File: rtl/adder_cs_pkg.sv
// Shared constants for the carry-select adder/subtractor pipeline.
package adder_cs_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLK   = 4;

endpackage

// File: rtl/adder_cs_blk.sv
// Combinational dual-carry block: produces sum/carry for both possible carry-ins.
module adder_cs_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] s0,
  output logic           co0,
  output logic [BLK-1:0] s1,
  output logic           co1
);

  assign {co0, s0} = {1'b0, a} + {1'b0, b};
  assign {co1, s1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/adder_cs_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 registers per-block dual sums; stage 2 ripples block carries and selects.
module adder_cs_pipe
  import adder_cs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLK   = DEFAULT_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLK;

  if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("adder_cs_pipe: WIDTH must be a multiple of BLK");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] s0_c, s1_c;
  logic [NBLK-1:0]  co0_c, co1_c;

  assign b_eff   = (sub == MODE_SUB) ? ~b : b;
  assign cin_eff = (sub == MODE_SUB) ? 1'b1 : ci;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    adder_cs_blk #(.BLK(BLK)) u_blk (
      .a   (a[k*BLK +: BLK]),
      .b   (b_eff[k*BLK +: BLK]),
      .s0  (s0_c[k*BLK +: BLK]),
      .co0 (co0_c[k]),
      .s1  (s1_c[k*BLK +: BLK]),
      .co1 (co1_c[k])
    );
  end

  logic             v1;
  logic [WIDTH-1:0] s0_q, s1_q;
  logic [NBLK-1:0]  co0_q, co1_q;
  logic             cin_q, a_msb_q, b_msb_q;
  logic             adv2, accept;

  // Stage 2 can take new data when empty or draining; stage 1 follows it.
  assign adv2     = !out_valid || out_ready;
  assign in_ready = !v1 || adv2;
  assign accept   = in_valid && in_ready;

  // Operand data is captured only on a real transfer, so idle X never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      co0_q   <= '0;
      co1_q   <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (accept) begin
        s0_q    <= s0_c;
        s1_q    <= s1_c;
        co0_q   <= co0_c;
        co1_q   <= co1_c;
        cin_q   <= cin_eff;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  logic [NBLK:0]    carry;
  logic [WIDTH-1:0] sel_s;
  logic             ovf_c;

  always_comb begin
    carry    = '0;
    sel_s    = '0;
    carry[0] = cin_q;
    for (int k = 0; k < NBLK; k++) begin
      sel_s[k*BLK +: BLK] = carry[k] ? s1_q[k*BLK +: BLK] : s0_q[k*BLK +: BLK];
      carry[k+1]          = co0_q[k] | (co1_q[k] & carry[k]);
    end
    ovf_c = (a_msb_q == b_msb_q) && (sel_s[WIDTH-1] != a_msb_q);
  end

  // Result registers hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        s   <= sel_s;
        co  <= carry[NBLK];
        ovf <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_cs_pipe.sv
// Self-checking bench: directed steps with scoreboard queues for three parameterisations.
module tb_adder_cs_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [31:0] a, b, s;

  logic       n8_in_valid, n8_in_ready, n8_ci, n8_sub, n8_out_valid, n8_co, n8_ovf;
  logic [7:0] n8_a, n8_b, n8_s;
  logic        n64_in_valid, n64_in_ready, n64_ci, n64_sub, n64_out_valid, n64_co, n64_ovf;
  logic [63:0] n64_a, n64_b, n64_s;
  logic        alt_out_ready = 1'b1;

  int compared   = 0;
  int mismatched = 0;
  int n_out      = 0;
  int cyc        = 0;

  logic [65:0] q_main[$];
  logic [65:0] q_n8[$];
  logic [65:0] q_n64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adder_cs_pipe #(.WIDTH(32), .BLK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  adder_cs_pipe #(.WIDTH(8), .BLK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
    .a(n8_a), .b(n8_b), .ci(n8_ci), .sub(n8_sub), .out_valid(n8_out_valid),
    .out_ready(alt_out_ready), .s(n8_s), .co(n8_co), .ovf(n8_ovf)
  );

  adder_cs_pipe #(.WIDTH(64), .BLK(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(n64_in_valid), .in_ready(n64_in_ready),
    .a(n64_a), .b(n64_b), .ci(n64_ci), .sub(n64_sub), .out_valid(n64_out_valid),
    .out_ready(alt_out_ready), .s(n64_s), .co(n64_co), .ovf(n64_ovf)
  );

  // Reference: plain wide addition of a + b' + cin, result packed as {ovf, co, s}.
  function automatic logic [65:0] model(int w, logic [63:0] a_i, logic [63:0] b_i,
                                        logic ci_i, logic sub_i);
    logic [63:0] mask, am, bp, sm;
    logic [64:0] sum;
    logic        cin, co_m, ovf_m;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am    = a_i & mask;
    bp    = (sub_i ? ~b_i : b_i) & mask;
    cin   = sub_i ? 1'b1 : ci_i;
    sum   = {1'b0, am} + {1'b0, bp} + {64'd0, cin};
    sm    = sum[63:0] & mask;
    co_m  = sum[w];
    ovf_m = (am[w-1] == bp[w-1]) && (sm[w-1] != am[w-1]);
    return {ovf_m, co_m, sm};
  endfunction

  task automatic checkOutput(string tag, logic [65:0] observed, logic [65:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic boundExpired(string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  // Offer one bundle starting at a negedge; returns at the negedge after it is accepted.
  task automatic applyStimulus(logic [31:0] a_i, logic [31:0] b_i, logic ci_i, logic sub_i);
    bit done = 0;
    in_valid = 1'b1;
    a = a_i; b = b_i; ci = ci_i; sub = sub_i;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (in_ready) begin
        q_main.push_back(model(32, {32'd0, a_i}, {32'd0, b_i}, ci_i, sub_i));
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) boundExpired("accept_timeout");
    in_valid = 1'b0;
    a = 'x; b = 'x; ci = 1'bx; sub = 1'bx;
  endtask

  task automatic waitIdle(string tag);
    for (int i = 0; i < 20; i++) begin
      if (q_main.size() == 0 && !out_valid) break;
      @(negedge clk); #1;
    end
    checkOutput(tag, 66'(q_main.size()), 66'd0);
  endtask

  // Result monitors sample mid-low-phase, after the drivers have settled.
  always begin
    logic [65:0] exp_v;
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      if (q_main.size() == 0) boundExpired("main_unexpected_output");
      else begin
        exp_v = q_main.pop_front();
        checkOutput("main_result", {ovf, co, 32'd0, s}, exp_v);
        n_out++;
      end
    end
  end

  always begin
    logic [65:0] exp_v;
    @(negedge clk); #2;
    if (rst_n && n8_out_valid) begin
      if (q_n8.size() == 0) boundExpired("n8_unexpected_output");
      else begin
        exp_v = q_n8.pop_front();
        checkOutput("n8_result", {n8_ovf, n8_co, 56'd0, n8_s}, exp_v);
      end
    end
  end

  always begin
    logic [65:0] exp_v;
    @(negedge clk); #2;
    if (rst_n && n64_out_valid) begin
      if (q_n64.size() == 0) boundExpired("n64_unexpected_output");
      else begin
        exp_v = q_n64.pop_front();
        checkOutput("n64_result", {n64_ovf, n64_co, n64_s}, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [65:0] held;
    int          cs, ce, n0;
    logic [63:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    n8_in_valid = 1'b0; n8_a = '0; n8_b = '0; n8_ci = 1'b0; n8_sub = 1'b0;
    n64_in_valid = 1'b0; n64_a = '0; n64_b = '0; n64_ci = 1'b0; n64_sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 66'(out_valid), 66'd0);
    checkOutput("reset_s", 66'(s), 66'd0);
    checkOutput("reset_co_ovf", 66'({co, ovf}), 66'd0);
    checkOutput("reset_in_ready", 66'(in_ready), 66'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] step 1: simple add and latency");
    applyStimulus(32'h5, 32'h3, 1'b0, 1'b0);
    #1 checkOutput("t1_not_yet_valid", 66'(out_valid), 66'd0);
    @(negedge clk); #1;
    checkOutput("t1_valid", 66'(out_valid), 66'd1);
    checkOutput("t1_sum", {ovf, co, 32'd0, s}, {2'b00, 64'd8});
    waitIdle("t1_drain");

    $display("[TB] step 2/3: full carry, overflow, subtract");
    @(negedge clk);
    applyStimulus(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    applyStimulus(32'h3, 32'h5, 1'b0, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    waitIdle("t3_drain");

    $display("[TB] step 4: 16 back-to-back bundles");
    @(negedge clk);
    n0 = n_out;
    cs = cyc;
    for (int i = 0; i < 16; i++)
      applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
    ce = cyc;
    checkOutput("t4_one_per_cycle", 66'(ce - cs), 66'd16);
    waitIdle("t4_drain");
    checkOutput("t4_result_count", 66'(n_out - n0), 66'd16);

    $display("[TB] step 5: stall with three bundles offered");
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    in_valid = 1'b1; a = 32'hCAFE_0000; b = 32'h0000_BEEF; ci = 1'b1; sub = 1'b0;
    #1;
    checkOutput("t5_in_ready_low", 66'(in_ready), 66'd0);
    checkOutput("t5_out_valid", 66'(out_valid), 66'd1);
    held = {ovf, co, 32'd0, s};
    checkOutput("t5_head", held, model(32, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checkOutput("t5_hold_out", {ovf, co, 32'd0, s}, held);
      checkOutput("t5_hold_ready", 66'({out_valid, in_ready}), 66'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("t5_release_ready", 66'(in_ready), 66'd1);
    q_main.push_back(model(32, 64'hCAFE_0000, 64'h0000_BEEF, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0; a = 'x; b = 'x; ci = 1'bx; sub = 1'bx;
    waitIdle("t5_drain");

    $display("[TB] step 6: reset with two in flight");
    @(negedge clk);
    applyStimulus(32'h0000_0AAA, 32'h0000_0555, 1'b0, 1'b0);
    applyStimulus(32'h0F0F_0F0F, 32'h00F0_00F0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_out_valid_reset", 66'(out_valid), 66'd0);
    checkOutput("t6_s_reset", 66'({s, co, ovf}), 66'd0);
    q_main.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    repeat (4) @(negedge clk);
    #1 checkOutput("t6_no_stale", 66'({out_valid, 32'(n_out - n0)}), 66'd0);
    @(negedge clk);
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
    waitIdle("t6_recover");

    $display("[TB] step 7: WIDTH=8/BLK=2 and WIDTH=64/BLK=8 sweep");
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      n8_in_valid = 1'b1; n8_a = ra[7:0]; n8_b = rb[7:0];
      n8_ci = ra[40]; n8_sub = rb[41];
      n64_in_valid = 1'b1; n64_a = ra; n64_b = rb;
      n64_ci = rb[50]; n64_sub = ra[51];
      #1;
      if (n8_in_ready)
        q_n8.push_back(model(8, {56'd0, n8_a}, {56'd0, n8_b}, n8_ci, n8_sub));
      else boundExpired("n8_ready");
      if (n64_in_ready)
        q_n64.push_back(model(64, n64_a, n64_b, n64_ci, n64_sub));
      else boundExpired("n64_ready");
      @(negedge clk);
    end
    n8_in_valid = 1'b0; n8_a = 'x; n8_b = 'x;
    n64_in_valid = 1'b0; n64_a = 'x; n64_b = 'x;
    repeat (4) @(negedge clk);
    #3;
    checkOutput("n8_drain", 66'(q_n8.size()), 66'd0);
    checkOutput("n64_drain", 66'(q_n64.size()), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
